pll_lock_sequencer: RTL

//  Sequences start-up of one fabric PLL from the free-running init clock. It holds PLL reset,

---
 rtl/pll_lock_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Brings up one fabric PLL from the free-running init clock. The PLL is held
//   in reset, released, and given a bounded window to lock. Lock must then stay
//   high for a run of consecutive cycles before it is reported. If the window
//   expires, the sequencer retries with the next charge-pump / loop-filter
//   setting. When all attempts are used up, it parks in a failed state. A lock
//   loss after reporting lock restarts the same attempt.
//
// Ports
//   init_clk  in   1  sequencer clock (board oscillator, never PLL-derived)
//   reset     in   1  synchronous, active-high
//   restart   in   1  one-cycle pulse: restart from attempt 0
//   pll_lock  in   1  raw PLL lock, asynchronous to init_clk
//   pll_rst   out  1  PLL reset, active-high (registered)
//   icpsel    out  6  charge-pump current select (registered)
//   lpfres    out  3  loop-filter resistor select (registered)
//   locked    out  1  debounced lock (registered)
//   fail      out  1  every attempt timed out (registered)
//   attempt   out  3  current attempt index
//   loss_cnt  out  8  lock-loss events since reset, saturating
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int CLK_PERIOD    = 20,
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 4,
  parameter int ICP_INIT      = 16,
  parameter int ICP_STEP      = 4,
  parameter int LPF_INIT      = 2
) (
  input  logic       init_clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic       locked,
  output logic       fail,
  output logic [2:0] attempt,
  output logic [7:0] loss_cnt
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_DONE = SW'(STABLE_CYCLES);
  localparam logic [2:0]    ATT_LAST    = 3'(MAX_RETRY - 1);

  if (CLK_PERIOD < 1 || RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
      MAX_RETRY < 1 || MAX_RETRY > 8) begin : g_bad_params
    $error("pll_lock_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE_CHK = 3'd2,
    ST_LOCKED     = 3'd3,
    ST_FAIL       = 3'd4
  } state_t;

  // Charge-pump setting for a given attempt, saturating at the 6-bit maximum.
  function automatic logic [5:0] icp_for(input logic [2:0] a);
    int sum;
    sum = ICP_INIT + ICP_STEP * int'(a);
    if (sum > 63) begin
      icp_for = 6'd63;
    end else begin
      icp_for = sum[5:0];
    end
  endfunction

  // Loop-filter setting for a given attempt, wrapping modulo 8.
  function automatic logic [2:0] lpf_for(input logic [2:0] a);
    int sum;
    sum = LPF_INIT + int'(a);
    lpf_for = sum[2:0];
  endfunction

  state_t          state_r, state_nx;
  logic            sync1_r, lock_s_r;
  logic [RW-1:0]   rst_cnt_r, rst_cnt_nx;
  logic [TW-1:0]   to_cnt_r, to_cnt_nx;
  logic [SW-1:0]   stable_cnt_r, stable_cnt_nx;
  logic [2:0]      attempt_r, attempt_nx;
  logic [7:0]      loss_cnt_r, loss_cnt_nx;
  logic [5:0]      icp_r;
  logic [2:0]      lpf_r;
  logic            pll_rst_r, locked_r, fail_r;
  logic            timeout_s;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge init_clk) begin
    if (reset) begin
      sync1_r  <= 1'b0;
      lock_s_r <= 1'b0;
    end else begin
      sync1_r  <= pll_lock;
      lock_s_r <= sync1_r;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nx      = state_r;
    rst_cnt_nx    = rst_cnt_r;
    to_cnt_nx     = to_cnt_r;
    stable_cnt_nx = stable_cnt_r;
    attempt_nx    = attempt_r;
    loss_cnt_nx   = loss_cnt_r;
    // The counter sits at TO_LAST during the last allowed cycle of the window.
    timeout_s     = (to_cnt_r == TO_LAST);

    if (restart) begin
      state_nx      = ST_RESET_HOLD;
      rst_cnt_nx    = '0;
      to_cnt_nx     = '0;
      stable_cnt_nx = '0;
      attempt_nx    = 3'd0;
    end else begin
      case (state_r)
        ST_RESET_HOLD: begin
          // Timeout counter is held at zero, so WAIT_LOCK starts clean.
          to_cnt_nx     = '0;
          stable_cnt_nx = '0;
          if (rst_cnt_r == RST_LAST) begin
            state_nx   = ST_WAIT_LOCK;
            rst_cnt_nx = '0;
          end else begin
            rst_cnt_nx = rst_cnt_r + RW'(1);
          end
        end

        ST_WAIT_LOCK: begin
          to_cnt_nx = to_cnt_r + TW'(1);
          if (timeout_s) begin
            stable_cnt_nx = '0;
            rst_cnt_nx    = '0;
            if (attempt_r < ATT_LAST) begin
              attempt_nx = attempt_r + 3'd1;
              state_nx   = ST_RESET_HOLD;
            end else begin
              state_nx   = ST_FAIL;
            end
          end else if (lock_s_r) begin
            state_nx      = ST_STABLE_CHK;
            stable_cnt_nx = SW'(1);
          end else begin
            stable_cnt_nx = '0;
          end
        end

        ST_STABLE_CHK: begin
          to_cnt_nx = to_cnt_r + TW'(1);
          // A completed stable run takes priority over a simultaneous timeout.
          if (stable_cnt_r == STABLE_DONE) begin
            state_nx = ST_LOCKED;
          end else if (timeout_s) begin
            stable_cnt_nx = '0;
            rst_cnt_nx    = '0;
            if (attempt_r < ATT_LAST) begin
              attempt_nx = attempt_r + 3'd1;
              state_nx   = ST_RESET_HOLD;
            end else begin
              state_nx   = ST_FAIL;
            end
          end else if (!lock_s_r) begin
            state_nx      = ST_WAIT_LOCK;
            stable_cnt_nx = '0;
          end else begin
            stable_cnt_nx = stable_cnt_r + SW'(1);
          end
        end

        ST_LOCKED: begin
          if (!lock_s_r) begin
            state_nx      = ST_RESET_HOLD;
            rst_cnt_nx    = '0;
            stable_cnt_nx = '0;
            if (loss_cnt_r != 8'hFF) begin
              loss_cnt_nx = loss_cnt_r + 8'd1;
            end else begin
              loss_cnt_nx = loss_cnt_r;
            end
          end else begin
            state_nx = ST_LOCKED;
          end
        end

        ST_FAIL: begin
          state_nx = ST_FAIL;
        end

        default: begin
          state_nx      = ST_RESET_HOLD;
          rst_cnt_nx    = '0;
          to_cnt_nx     = '0;
          stable_cnt_nx = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs follow the next state.
  always_ff @(posedge init_clk) begin
    if (reset) begin
      state_r      <= ST_RESET_HOLD;
      rst_cnt_r    <= '0;
      to_cnt_r     <= '0;
      stable_cnt_r <= '0;
      attempt_r    <= 3'd0;
      loss_cnt_r   <= 8'd0;
      icp_r        <= icp_for(3'd0);
      lpf_r        <= lpf_for(3'd0);
      pll_rst_r    <= 1'b1;
      locked_r     <= 1'b0;
      fail_r       <= 1'b0;
    end else begin
      state_r      <= state_nx;
      rst_cnt_r    <= rst_cnt_nx;
      to_cnt_r     <= to_cnt_nx;
      stable_cnt_r <= stable_cnt_nx;
      attempt_r    <= attempt_nx;
      loss_cnt_r   <= loss_cnt_nx;
      // Settings only move while the PLL is (about to be) held in reset.
      if (state_nx == ST_RESET_HOLD) begin
        icp_r <= icp_for(attempt_nx);
        lpf_r <= lpf_for(attempt_nx);
      end else begin
        icp_r <= icp_r;
        lpf_r <= lpf_r;
      end
      pll_rst_r <= (state_nx == ST_RESET_HOLD) || (state_nx == ST_FAIL);
      locked_r  <= (state_nx == ST_LOCKED);
      fail_r    <= (state_nx == ST_FAIL);
    end
  end

  assign pll_rst  = pll_rst_r;
  assign icpsel   = icp_r;
  assign lpfres   = lpf_r;
  assign locked   = locked_r;
  assign fail     = fail_r;
  assign attempt  = attempt_r;
  assign loss_cnt = loss_cnt_r;

endmodule
